bram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port 64 KiB byte-wide `bram`. It accepts byte read and write requests from two independent masters, such as a host loader and the gate-test engine. It serialises them with round-robin fairness and drives the BRAM `mode`/`address`/`byte_in` pins. It returns read data with a one-cycle acknowledge pulse per request.

---
 rtl/bram_pkg.sv | 16 +
 rtl/bram.sv | 35 +++
 rtl/bram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_bram_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared constants and types for the byte-wide BRAM and its arbiter.
package bram_pkg;

    localparam int BRAM_ADDR_W = 32'd16;
    localparam int BRAM_DATA_W = 32'd8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

endpackage

// File: rtl/bram.sv
// Single-port byte-wide block RAM with registered read data.
// Contents are intentionally not reset so they survive an arbiter reset.
module bram
    import bram_pkg::*;
#(
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W
) (
    input  logic              clk,
    input  logic              mode,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] byte_in,
    output logic [DATA_W-1:0] byte_out
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] byte_out_d;
    logic [DATA_W-1:0] byte_out_q;

    // Read path: the addressed byte, captured on the next edge.
    always_comb begin
        byte_out_d = mem[address];
    end

    // Storage array write and registered read.
    always_ff @(posedge clk) begin
        if (mode == MODE_WRITE) begin
            mem[address] <= byte_in;
        end
        byte_out_q <= byte_out_d;
    end

    assign byte_out = byte_out_q;

endmodule

// File: rtl/bram_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the internal BRAM.
// Each transaction walks IDLE -> ACCESS -> DONE; the ack pulse is registered
// out of DONE, so it is visible in the cycle after DONE.
module bram_arbiter
    import bram_pkg::*;
#(
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic [DATA_W-1:0] bdin_q, bdin_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              busy_q, busy_d;
    logic              any_req_s;
    logic              win_s;
    logic [DATA_W-1:0] bram_dout_s;

    // Round-robin pick: on a tie the port not granted last wins.
    always_comb begin
        any_req_s = req0 | req1;
        if (req0 && req1) begin
            win_s = ~last_grant_q;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: latch the winner, drive BRAM pins, ack and capture read data.
    always_comb begin
        last_grant_d = last_grant_q;
        we_d         = we_q;
        mode_d       = MODE_READ;
        baddr_d      = baddr_q;
        bdin_d       = bdin_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    last_grant_d = win_s;
                    we_d         = win_s ? we1 : we0;
                    mode_d       = win_s ? we1 : we0;
                    baddr_d      = win_s ? addr1 : addr0;
                    bdin_d       = win_s ? wdata1 : wdata0;
                end else begin
                    mode_d = MODE_READ;
                end
            end
            ACCESS: begin
                mode_d = MODE_READ;
            end
            DONE: begin
                ack0_d = ~last_grant_q;
                ack1_d = last_grant_q;
                if (we_q == MODE_READ) begin
                    if (last_grant_q) begin
                        rdata1_d = bram_dout_s;
                    end else begin
                        rdata0_d = bram_dout_s;
                    end
                end else begin
                    rdata0_d = rdata0_q;
                    rdata1_d = rdata1_q;
                end
            end
            default: begin
                mode_d = MODE_READ;
            end
        endcase
    end

    // Datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            we_q         <= MODE_READ;
            mode_q       <= MODE_READ;
            baddr_q      <= {ADDR_W{1'b0}};
            bdin_q       <= {DATA_W{1'b0}};
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= {DATA_W{1'b0}};
            rdata1_q     <= {DATA_W{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            mode_q       <= mode_d;
            baddr_q      <= baddr_d;
            bdin_q       <= bdin_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
        end
    end

    bram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bram (
        .clk      (clk),
        .mode     (mode_q),
        .address  (baddr_q),
        .byte_in  (bdin_q),
        .byte_out (bram_dout_s)
    );

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter against a memory/round-robin model.
module tb_bram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, ack0, req1, we1, ack1, busy;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1, rdata0, rdata1;

    int errors = 0;
    int checks = 0;

    logic [7:0]  ref_mem [int];
    logic [7:0]  exp_rdata [2];
    int          last_win;
    logic        cw [2];
    logic [15:0] ca [2];
    logic [7:0]  cd [2];
    logic [15:0] pool [6] = '{16'h0000, 16'hFFFF, 16'h0010, 16'h1234, 16'h0040, 16'h00FF};

    bram_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic drive(input int p, input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? ack0 : ack1;
    endfunction

    function automatic logic [7:0] rdata_of(input int p);
        return (p == 0) ? rdata0 : rdata1;
    endfunction

    // Pick a random transaction for port p; reads only target written bytes.
    task automatic new_txn(input int p);
        ca[p] = pool[$urandom_range(0, 5)];
        cw[p] = 1'($urandom_range(0, 1));
        if (!ref_mem.exists(int'(ca[p]))) cw[p] = 1'b1;
        cd[p] = 8'($urandom);
    endtask

    // One uncontended transaction on port p; called at a negedge with the arbiter idle.
    task automatic single(input int p, input logic w, input logic [15:0] a, input logic [7:0] d, input string tag);
        logic [2:0] exp_v;
        drive(p, 1'b1, w, a, d);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n < 3) exp_v = 3'b001;
            else exp_v = (p == 0) ? 3'b100 : 3'b010;
            checks++;
            if ({ack0, ack1, busy} !== exp_v) begin
                errors++;
                $display("FAIL %s cycle%0d ack0/ack1/busy got %b want %b", tag, n, {ack0, ack1, busy}, exp_v);
            end
        end
        drive(p, 1'b0, 1'b0, 16'h0000, 8'h00);
        if (w) ref_mem[int'(a)] = d;
        else exp_rdata[p] = ref_mem[int'(a)];
        last_win = p;
        checks++;
        if (rdata_of(p) !== exp_rdata[p] || rdata_of(1 - p) !== exp_rdata[1 - p]) begin
            errors++;
            $display("FAIL %s rdata got %h/%h want %h/%h", tag, rdata0, rdata1, exp_rdata[0], exp_rdata[1]);
        end
    endtask

    // Both ports request until n_acks transactions complete, starting from cw/ca/cd.
    task automatic run_pair(input int n_acks, input string tag);
        int   issued, acks, gap, cyc;
        int   wt [2];
        logic pend [2];
        issued = 2; acks = 0; gap = 0; cyc = 0;
        wt[0] = 0; wt[1] = 0; pend[0] = 1'b1; pend[1] = 1'b1;
        drive(0, 1'b1, cw[0], ca[0], cd[0]);
        drive(1, 1'b1, cw[1], ca[1], cd[1]);
        while (acks < n_acks && cyc < 80) begin
            @(negedge clk);
            cyc++; gap++; wt[0]++; wt[1]++;
            checks++;
            if (ack0 && ack1) begin
                errors++;
                $display("FAIL %s both acks high at cycle %0d", tag, cyc);
            end
            for (int p = 0; p < 2; p++) begin
                if (ack_of(p) && !pend[p]) begin
                    checks++; errors++;
                    $display("FAIL %s spurious ack%0d at cycle %0d", tag, p, cyc);
                end else if (ack_of(p)) begin
                    checks++;
                    if (p != 1 - last_win) begin
                        errors++;
                        $display("FAIL %s order got port %0d want port %0d", tag, p, 1 - last_win);
                    end
                    checks++;
                    if (gap != 3) begin
                        errors++;
                        $display("FAIL %s ack spacing got %0d want 3", tag, gap);
                    end
                    checks++;
                    if (wt[p] > 6) begin
                        errors++;
                        $display("FAIL %s port%0d wait got %0d want <=6", tag, p, wt[p]);
                    end
                    if (cw[p]) ref_mem[int'(ca[p])] = cd[p];
                    else exp_rdata[p] = ref_mem[int'(ca[p])];
                    checks++;
                    if (rdata_of(p) !== exp_rdata[p]) begin
                        errors++;
                        $display("FAIL %s rdata%0d got %h want %h", tag, p, rdata_of(p), exp_rdata[p]);
                    end
                    last_win = p; gap = 0; acks++;
                    if (issued < n_acks) begin
                        new_txn(p);
                        drive(p, 1'b1, cw[p], ca[p], cd[p]);
                        wt[p] = 0; issued++;
                    end else begin
                        pend[p] = 1'b0;
                        drive(p, 1'b0, 1'b0, 16'h0000, 8'h00);
                    end
                end
            end
        end
        checks++;
        if (acks != n_acks) begin
            errors++;
            $display("FAIL %s timeout acks got %0d want %0d", tag, acks, n_acks);
        end
        drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
        repeat (2) @(negedge clk);
        checks++;
        if ({ack0, ack1, busy, rdata0, rdata1} !== 19'd0) begin
            errors++;
            $display("FAIL reset outputs got %b %b %b %h %h want all zero", ack0, ack1, busy, rdata0, rdata1);
        end
        rst = 1'b0;
        exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
        last_win = 1;
    endtask

    task automatic test_tie_from_reset;
        cw[0] = 1'b1; ca[0] = 16'h0010; cd[0] = 8'h11;
        cw[1] = 1'b1; ca[1] = 16'h0010; cd[1] = 8'h22;
        run_pair(2, "tie");
        single(0, 1'b0, 16'h0010, 8'h00, "tie_read");
    endtask

    task automatic test_write_read_p0;
        single(0, 1'b1, 16'h1234, 8'hA5, "p0_write");
        single(0, 1'b0, 16'h1234, 8'h00, "p0_read");
    endtask

    task automatic test_boundary;
        single(0, 1'b1, 16'hFFFF, 8'hFF, "bnd_wr_ffff");
        single(1, 1'b1, 16'h0000, 8'h01, "bnd_wr_0000");
        single(0, 1'b0, 16'hFFFF, 8'h00, "bnd_rd_ffff");
        single(1, 1'b0, 16'h0000, 8'h00, "bnd_rd_0000");
    endtask

    task automatic test_midflight;
        single(1, 1'b1, 16'h0300, 8'h33, "mf_pre");
        drive(1, 1'b1, 1'b1, 16'h0200, 8'h5C);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 16'h0300, 8'h99);
        @(negedge clk);
        checks++;
        if ({ack0, ack1, busy} !== 3'b001) begin
            errors++;
            $display("FAIL midflight done ack0/ack1/busy got %b want 001", {ack0, ack1, busy});
        end
        @(negedge clk);
        checks++;
        if ({ack0, ack1, busy} !== 3'b010) begin
            errors++;
            $display("FAIL midflight ack ack0/ack1/busy got %b want 010", {ack0, ack1, busy});
        end
        drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
        ref_mem[int'(16'h0200)] = 8'h5C;
        last_win = 1;
        single(0, 1'b0, 16'h0200, 8'h00, "mf_rd_0200");
        single(0, 1'b0, 16'h0300, 8'h00, "mf_rd_0300");
    endtask

    task automatic test_back_to_back;
        new_txn(0);
        new_txn(1);
        run_pair(8, "sustain");
    endtask

    task automatic test_random_single;
        int          p;
        logic        w;
        logic [15:0] a;
        for (int i = 0; i < 16; i++) begin
            p = $urandom_range(0, 1);
            a = pool[$urandom_range(0, 5)];
            w = 1'($urandom_range(0, 1));
            if (!ref_mem.exists(int'(a))) w = 1'b1;
            single(p, w, a, 8'($urandom), "rand");
        end
    endtask

    task automatic test_reset_mid;
        single(0, 1'b1, 16'h0040, 8'h00, "rm_pre");
        drive(0, 1'b1, 1'b1, 16'h0040, 8'h77);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({ack0, ack1, busy, rdata0, rdata1} !== 19'd0) begin
            errors++;
            $display("FAIL reset_mid outputs got %b %b %b %h %h want all zero", ack0, ack1, busy, rdata0, rdata1);
        end
        exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
        last_win = 1;
        drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if ({ack0, ack1, busy} !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid hold%0d ack0/ack1/busy got %b want 000", n, {ack0, ack1, busy});
            end
        end
        rst = 1'b0;
        single(1, 1'b0, 16'h0040, 8'h00, "rm_read");
    endtask

    initial begin
        test_reset;
        test_tie_from_reset;
        test_write_read_p0;
        test_boundary;
        test_midflight;
        test_back_to_back;
        test_random_single;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
